// File: rtl/des_wb_sequencer.sv
// des_wb_sequencer: feeds one 64-bit block at a time to a DES Wishbone slave.
// It writes the data words, writes the key only when it changed, starts the
// core, polls the finish flag, stops the core and reads the result back.
module des_wb_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned POLL_GAP   = 4,
  parameter int unsigned POLL_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_mode,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic        err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [3:0] {
    IDLE, WR_DH, WR_DL, WR_KH, WR_KL, START, POLL, GAP, STOP, RD_H, RD_L
  } state_t;

  localparam logic [31:0] OFS_CFG   = 32'h00;
  localparam logic [31:0] OFS_TX_H  = 32'h04;
  localparam logic [31:0] OFS_TX_L  = 32'h08;
  localparam logic [31:0] OFS_RX_H  = 32'h0C;
  localparam logic [31:0] OFS_RX_L  = 32'h10;
  localparam logic [31:0] OFS_KEY_H = 32'h14;
  localparam logic [31:0] OFS_KEY_L = 32'h18;

  // Last gap count value; only meaningful when POLL_GAP is non-zero.
  localparam logic [7:0]  GAP_LAST   = 8'(POLL_GAP - 1);
  localparam logic [16:0] POLL_LAST  = 17'(POLL_LIMIT);

  state_t      state;
  logic [63:0] data_q;
  logic [63:0] key_q;
  logic [63:0] last_key;
  logic        mode_q;
  logic        key_written;
  logic        timed_out;
  logic [7:0]  gap_cnt;
  logic [15:0] poll_cnt;

  logic        ack;
  logic        key_stale;
  logic        last_poll;
  logic        bus_state;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_adr;
  logic [31:0] req_dat;

  // A stray acknowledge outside an open cycle must never advance the FSM.
  assign ack       = wbm_cyc_o & wbm_ack_i;
  assign in_ready  = (state == IDLE) & ~out_valid & ~rst;
  assign busy      = (state != IDLE);
  assign key_stale = ~key_written | (key_q != last_key);
  assign last_poll = (({1'b0, poll_cnt}) + 17'd1) == POLL_LAST;

  // Bus request (direction, selects, address, data) implied by the current state.
  always_comb begin
    bus_state = 1'b1;
    req_we    = 1'b1;
    req_sel   = 4'hF;
    req_adr   = BASE_ADDR + OFS_CFG;
    req_dat   = '0;
    case (state)
      WR_DH: begin
        req_adr = BASE_ADDR + OFS_RX_H;
        req_dat = data_q[63:32];
      end
      WR_DL: begin
        req_adr = BASE_ADDR + OFS_RX_L;
        req_dat = data_q[31:0];
      end
      WR_KH: begin
        req_adr = BASE_ADDR + OFS_KEY_H;
        req_dat = key_q[63:32];
      end
      WR_KL: begin
        req_adr = BASE_ADDR + OFS_KEY_L;
        req_dat = key_q[31:0];
      end
      START: begin
        req_sel = 4'b0110;
        req_dat = {15'b0, mode_q, 7'b0, 1'b1, 8'b0};
      end
      POLL: begin
        req_we = 1'b0;
      end
      STOP: begin
        req_sel = 4'b0010;
      end
      RD_H: begin
        req_we  = 1'b0;
        req_adr = BASE_ADDR + OFS_TX_H;
      end
      RD_L: begin
        req_we  = 1'b0;
        req_adr = BASE_ADDR + OFS_TX_L;
      end
      default: begin
        bus_state = 1'b0;
        req_we    = 1'b0;
        req_sel   = '0;
        req_adr   = '0;
      end
    endcase
  end

  // Sequencer FSM with registered Wishbone master outputs and result buffer.
  // Every bus state spends its first cycle with cyc low, which provides the
  // mandatory idle cycle between transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err         <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      data_q      <= '0;
      key_q       <= '0;
      last_key    <= '0;
      mode_q      <= 1'b0;
      key_written <= 1'b0;
      timed_out   <= 1'b0;
      gap_cnt     <= '0;
      poll_cnt    <= '0;
    end else begin
      if (bus_state && !wbm_cyc_o) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= req_we;
        wbm_sel_o <= req_sel;
        wbm_adr_o <= req_adr;
        wbm_dat_o <= req_dat;
      end
      if (ack) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
        wbm_sel_o <= '0;
        wbm_adr_o <= '0;
        wbm_dat_o <= '0;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_q <= in_data;
            key_q  <= key;
            mode_q <= in_mode;
            state  <= WR_DH;
          end
        end
        WR_DH: if (ack) state <= WR_DL;
        WR_DL: if (ack) state <= key_stale ? WR_KH : START;
        WR_KH: if (ack) state <= WR_KL;
        WR_KL: begin
          if (ack) begin
            key_written <= 1'b1;
            last_key    <= key_q;
            state       <= START;
          end
        end
        START: begin
          if (!wbm_cyc_o) begin
            gap_cnt  <= '0;
            poll_cnt <= '0;
          end
          if (ack) state <= POLL;
        end
        POLL: begin
          if (ack) begin
            if (wbm_dat_i[0]) begin
              state <= STOP;
            end else begin
              poll_cnt <= poll_cnt + 16'd1;
              if (last_poll) begin
                err       <= 1'b1;
                timed_out <= 1'b1;
                state     <= STOP;
              end else if (POLL_GAP != 0) begin
                gap_cnt <= '0;
                state   <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= POLL;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        STOP: begin
          if (ack) begin
            if (timed_out) begin
              timed_out <= 1'b0;
              state     <= IDLE;
            end else begin
              state <= RD_H;
            end
          end
        end
        RD_H: begin
          if (ack) begin
            out_data[63:32] <= wbm_dat_i;
            state           <= RD_L;
          end
        end
        RD_L: begin
          if (ack) begin
            out_data[31:0] <= wbm_dat_i;
            out_valid      <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_wb_sequencer.sv
// tb_des_wb_sequencer: drives blocks into des_wb_sequencer, emulates the DES
// Wishbone slave and checks bus transfers and results against a job model.
module tb_des_wb_sequencer;

  localparam logic [31:0] BASE  = 32'h4000_0100;
  localparam int          GAP_P = 2;
  localparam int          LIMIT = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_mode;
  logic [63:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic        err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack, slv_ack, spur_en, spur_bit;

  assign ack = slv_ack | (spur_en & spur_bit & ~cyc);

  always #5 clk = ~clk;

  des_wb_sequencer #(
    .BASE_ADDR (BASE),
    .POLL_GAP  (GAP_P),
    .POLL_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .key(key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in for the DES core: real known-answer pairs, otherwise an invertible mix.
  function automatic logic [63:0] des_stub(input logic [63:0] d, input logic [63:0] k, input logic m);
    logic [63:0] x;
    if (k == 64'h133457799BBCDFF1 && !m && d == 64'h0123456789ABCDEF) return 64'h85E813540F0AB405;
    if (k == 64'h133457799BBCDFF1 && m && d == 64'h85E813540F0AB405) return 64'h0123456789ABCDEF;
    if (!m) return {d[50:0], d[63:51]} ^ k;
    x = d ^ k;
    return {x[12:0], x[63:13]};
  endfunction

  // Slave model state
  xfer_t       obs_q[$];
  xfer_t       exp_q[$];
  logic [63:0] s_recv, s_key, s_result;
  logic        s_mode, s_run;
  int          s_polls_left;
  int          fin_delay;
  bit          stuck;
  int          wait_max;

  // Slave: responds on the falling edge after a random number of wait cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    slv_ack = 1'b0;
    spur_bit = 1'b0;
    dat_i = '0;
    s_run = 1'b0;
    s_mode = 1'b0;
    s_polls_left = 0;
    s_recv = '0;
    s_key = '0;
    s_result = '0;
    forever begin
      @(negedge clk);
      spur_bit = 1'($urandom_range(1, 0));
      if (!cyc || !stb || slv_ack) begin
        slv_ack = 1'b0;
        wcnt = (wait_max == 0) ? 0 : int'($urandom_range(wait_max, 0));
      end else if (wcnt > 0) begin
        wcnt--;
      end else begin
        xfer_t x;
        x.we = we; x.adr = adr; x.sel = sel; x.dat = dat_o;
        obs_q.push_back(x);
        slv_ack = 1'b1;
        if (we) begin
          case (adr - BASE)
            32'h0C: s_recv[63:32] = dat_o;
            32'h10: s_recv[31:0]  = dat_o;
            32'h14: s_key[63:32]  = dat_o;
            32'h18: s_key[31:0]   = dat_o;
            32'h00: begin
              if (dat_o[8]) begin
                s_run = 1'b1;
                s_mode = dat_o[16];
                s_polls_left = fin_delay;
                s_result = des_stub(s_recv, s_key, dat_o[16]);
              end else begin
                s_run = 1'b0;
              end
            end
            default: ;
          endcase
        end else begin
          case (adr - BASE)
            32'h00: begin
              if (s_run && !stuck && s_polls_left == 0) begin
                dat_i = {15'b0, s_mode, 15'b0, 1'b1};
              end else begin
                dat_i = {15'b0, s_mode, 16'b0};
                if (s_polls_left > 0) s_polls_left--;
              end
            end
            32'h04: dat_i = s_result[63:32];
            32'h08: dat_i = s_result[31:0];
            default: dat_i = '0;
          endcase
        end
      end
    end
  end

  // Protocol monitor: stable request until ack, cyc drops right after ack, stb tracks cyc.
  initial begin
    logic        pc, pack;
    logic [68:0] pv;
    pc = 1'b0; pack = 1'b0; pv = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (stb !== cyc) viol++;
        if (pc && pack && cyc) viol++;
        if (pc && !pack && cyc && {we, sel, adr, dat_o} !== pv) viol++;
      end
      pc = cyc; pack = cyc & ack; pv = {we, sel, adr, dat_o};
    end
  end

  // Job-level reference model
  logic [63:0] mdl_key;
  bit          mdl_key_valid;
  bit          mdl_err;

  task automatic exp_push(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    xfer_t x;
    x.we = w; x.adr = a; x.sel = s; x.dat = d;
    exp_q.push_back(x);
  endtask

  task automatic expect_job(input logic [63:0] d, input logic [63:0] k, input logic m,
                            input int delay, input bit stk, output bit tmo);
    int reads;
    exp_q.delete();
    exp_push(1'b1, BASE + 32'h0C, 4'hF, d[63:32]);
    exp_push(1'b1, BASE + 32'h10, 4'hF, d[31:0]);
    if (!mdl_key_valid || k != mdl_key) begin
      exp_push(1'b1, BASE + 32'h14, 4'hF, k[63:32]);
      exp_push(1'b1, BASE + 32'h18, 4'hF, k[31:0]);
      mdl_key = k;
      mdl_key_valid = 1'b1;
    end
    exp_push(1'b1, BASE, 4'b0110, (32'(m) << 16) | 32'h100);
    tmo = stk || (delay + 1 > LIMIT);
    reads = tmo ? LIMIT : delay + 1;
    for (int i = 0; i < reads; i++) exp_push(1'b0, BASE, 4'hF, 32'h0);
    exp_push(1'b1, BASE, 4'b0010, 32'h0);
    if (!tmo) begin
      exp_push(1'b0, BASE + 32'h04, 4'hF, 32'h0);
      exp_push(1'b0, BASE + 32'h08, 4'hF, 32'h0);
    end
  endtask

  task automatic run_job(input logic [63:0] d, input logic [63:0] k, input logic m,
                         input int delay, input bit stk, input int hold, input int wmax);
    bit          tmo, stable;
    logic [63:0] res;
    int          t;
    fin_delay = delay;
    stuck = stk;
    wait_max = wmax;
    expect_job(d, k, m, delay, stk, tmo);
    res = des_stub(d, k, m);
    obs_q.delete();
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_mode = m; key = k;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = {$urandom, $urandom};
    key = {$urandom, $urandom};
    in_mode = ~m;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 3000);
    check_eq("job_done", busy, 0);
    check_eq("out_valid", out_valid, !tmo);
    if (tmo) mdl_err = 1'b1;
    check_eq("err", err, mdl_err);
    if (!tmo) begin
      check_eq("out_data", out_data, res);
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_data !== res || in_ready !== 1'b0 || cyc !== 1'b0) stable = 1'b0;
      end
      check_eq("hold_stable", stable, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("out_valid_clr", out_valid, 0);
      check_eq("in_ready_back", in_ready, 1);
    end
    check_eq("xfer_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_eq($sformatf("xfer%0d_hdr", i), {obs_q[i].we, obs_q[i].sel, obs_q[i].adr},
               {exp_q[i].we, exp_q[i].sel, exp_q[i].adr});
      if (exp_q[i].we) check_eq($sformatf("xfer%0d_dat", i), obs_q[i].dat, exp_q[i].dat);
    end
  endtask

  logic [63:0] keys [3];

  initial begin
    int t;
    keys[0] = 64'h133457799BBCDFF1;
    keys[1] = 64'h0E329232EA6D0D73;
    keys[2] = 64'hA5A5_0F0F_1234_5678;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; key = '0;
    out_ready = 1'b0; spur_en = 1'b0;
    fin_delay = 0; stuck = 1'b0; wait_max = 0;
    mdl_key = '0; mdl_key_valid = 1'b0; mdl_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cyc", cyc, 0);
    check_eq("rst_stb", stb, 0);
    check_eq("rst_we", we, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_adr", adr, 0);
    check_eq("rst_dat", dat_o, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_in_ready", in_ready, 1);

    // Known-answer encrypt with 20 cycles of output backpressure
    run_job(64'h0123456789ABCDEF, keys[0], 1'b0, 2, 1'b0, 20, 0);
    // Decrypt with the same key: no key writes, start word 0x00010100
    run_job(64'h85E813540F0AB405, keys[0], 1'b1, 0, 1'b0, 0, 0);
    // Key change brings the key writes back
    run_job(64'hDEADBEEF_CAFEF00D, keys[1], 1'b0, 1, 1'b0, 1, 1);
    // Finish never rises: timeout after LIMIT reads, err sticky
    run_job(64'h1111_2222_3333_4444, keys[1], 1'b1, 0, 1'b1, 0, 0);
    // Finish on exactly the LIMIT-th read completes normally
    run_job(64'h5555_6666_7777_8888, keys[1], 1'b0, LIMIT - 1, 1'b0, 2, 0);
    // Finish one read too late times out
    run_job(64'h9999_AAAA_BBBB_CCCC, keys[1], 1'b0, LIMIT, 1'b0, 0, 2);

    // Reset while a poll read is outstanding
    fin_delay = 0; stuck = 1'b1; wait_max = 3;
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h0F0F_0F0F_F0F0_F0F0; in_mode = 1'b0; key = keys[1];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(cyc && stb && !we && adr == BASE) && t < 500);
    check_eq("poll_seen", cyc && stb && !we && adr == BASE, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_cyc", cyc, 0);
    check_eq("mid_rst_stb", stb, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    mdl_key_valid = 1'b0;
    mdl_err = 1'b0;
    check_eq("mid_rst_err", err, 0);
    // Same key as before the reset must still be rewritten
    run_job(64'h0246_8ACE_1357_9BDF, keys[1], 1'b0, 1, 1'b0, 0, 0);

    // Randomized jobs with stray acks while the bus is idle
    spur_en = 1'b1;
    for (int j = 0; j < 16; j++) begin
      run_job({$urandom, $urandom}, keys[$urandom_range(2, 0)], 1'($urandom_range(1, 0)),
              int'($urandom_range(5, 0)), ($urandom_range(7, 0) == 0),
              int'($urandom_range(4, 0)), int'($urandom_range(2, 0)));
    end
    spur_en = 1'b0;

    check_eq("wb_protocol", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/des_wb_sequencer.md
DES_WB_SEQUENCER -- requirements
Module: des_wb_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0, meaning the byte base address of the DES Wishbone slave.
REQ-002 SHALL have parameter POLL_GAP, default 4, meaning the idle cycles between consecutive finish-poll reads (range 0..255).
REQ-003 SHALL have parameter POLL_LIMIT, default 64, meaning the maximum number of finish-poll reads before timeout (range 1..65535).
REQ-004 SHALL have the following ports, one per line: name, direction, width, meaning.
 clk  in  1  single clock; all logic on rising edge
 rst  in  1  synchronous, active-high reset
 in_valid  in  1  input block offered
 in_ready  out  1  input block accepted when in_valid&in_ready
 in_data  in  64  plaintext/ciphertext block, [63:32] high word
 in_mode  in  1  0 encrypt, 1 decrypt; sampled with in_data
 key  in  64  DES key; sampled with in_data
 out_valid  out  1  result block available
 out_ready  in  1  consumer accepts when out_valid&out_ready
 out_data  out  64  result block, [63:32] high word
 busy  out  1  high whenever FSM is not IDLE
 err  out  1  sticky poll-timeout flag
 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master strobes
 wbm_sel_o  out  4  byte selects
 wbm_adr_o  out  32  byte address
 wbm_dat_o  out  32  write data
 wbm_ack_i  in  1  slave acknowledge
 wbm_dat_i  in  32  read data

Function
REQ-005 SHALL address slave registers at BASE_ADDR offsets: CFG 0x00, TRANSMIT_H32 0x04, TRANSMIT_L32 0x08, RECEIVE_H32 0x0C, RECEIVE_L32 0x10, KEY_H32 0x14, KEY_L32 0x18.
REQ-006 SHALL define CFG bits: bit 8 start, bit 16 mode (1 decrypt), bit 0 finish (read-only).
REQ-007 SHALL run a classic single-transfer bus cycle: cyc, stb, we, sel, adr, dat registered and held constant until the first edge with wbm_ack_i=1; all deasserted the following cycle; at least one idle cycle between transfers.
REQ-008 SHALL ignore wbm_ack_i while cyc is low.
REQ-009 SHALL assert in_ready only in IDLE with out_valid low; on handshake, capture in_data, in_mode, key and leave IDLE next cycle.
REQ-010 SHALL sequence states IDLE -> WR_DH -> WR_DL -> [WR_KH -> WR_KL] -> START -> POLL -> (GAP -> POLL)* -> STOP -> RD_H -> RD_L -> IDLE.
REQ-011 SHALL write captured data to RECEIVE_H32/RECEIVE_L32 with sel 4'hF.
REQ-012 SHALL perform WR_KH/WR_KL (sel 4'hF) only when no key has been written since reset or the captured key differs from the last key written; otherwise skip to START.
REQ-013 SHALL, in START, write CFG with sel 4'b0110 and data {15'b0, mode, 7'b0, 1'b1, 8'b0}.
REQ-014 SHALL, in POLL, read CFG with sel 4'hF; finish=1 goes to STOP; finish=0 increments poll count and waits POLL_GAP idle cycles.
REQ-015 SHALL, on the POLL_LIMIT-th read returning finish=0, set err, drop the block, write STOP, return to IDLE without asserting out_valid.
REQ-016 SHALL, in STOP, write CFG with sel 4'b0010, data 0.
REQ-017 SHALL read TRANSMIT_H32 into out_data[63:32] and TRANSMIT_L32 into out_data[31:0], assert out_valid on the cycle after RD_L ack, hold out_data/out_valid stable until out_ready.
REQ-018 SHALL clear out_valid on the edge where out_valid&out_ready; in_ready may rise the following cycle.
REQ-019 SHALL clear err only by reset; err does not block further jobs.
REQ-020 SHALL use an 8-bit gap counter and a 16-bit poll counter, both cleared on entry to START.

Reset
REQ-021 SHALL, with rst high at a clock edge, force IDLE; in_ready=0 during reset; out_valid, busy, err, wbm_cyc_o, wbm_stb_o, wbm_we_o = 0; wbm_sel_o, wbm_adr_o, wbm_dat_o, out_data = 0; key-written flag cleared.
REQ-022 SHALL abandon any in-flight bus cycle on reset (cyc/stb low the next cycle); the first job after reset rewrites the key.

Verification
REQ-023 Encrypt: in_data 0123456789ABCDEF, key 133457799BBCDFF1, mode 0, zero-wait slave -> out_data 85E813540F0AB405; bus log 0C,10,14,18,00(W),00(R)...,00(W),04,08.
REQ-024 Decrypt same key: in_data 85E813540F0AB405, mode 1 -> out_data 0123456789ABCDEF, no KEY writes, START data 32'h00010100.
REQ-025 Key change: third block with key 0E329232EA6D0D73 -> KEY_H32/KEY_L32 writes reappear before START.
REQ-026 Backpressure: out_ready low 20 cycles -> out_valid and out_data stable, in_ready 0, no bus activity.
REQ-027 Timeout: slave finish stuck 0, POLL_LIMIT=4 -> exactly 4 CFG reads, STOP write, err=1, no out_valid, next block processes normally.
REQ-028 Reset mid-POLL with stb high -> next cycle cyc/stb 0, busy 0, out_valid 0; next job writes key.
